// File: rtl/addsub_arbiter.sv
// Shared W-bit add/subtract unit arbitrated among NREQ requesters, tagged registered result.
// Define ADDSUB_ARB_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module addsub_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ-1:0]   i_op,
    input  logic [NREQ*W-1:0] i_a,
    input  logic [NREQ*W-1:0] i_b,
    output logic [NREQ-1:0]   o_gnt,
    output logic              o_busy,
    output logic              o_res_valid,
    output logic [2:0]        o_res_id,
    output logic [W-1:0]      o_res_sum,
    output logic              o_res_carry
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              w_any_req;
    logic              w_hit;
    logic [IW-1:0]     w_win_idx;
    logic [NREQ-1:0]   w_win_onehot;
    logic              w_sel_op;
    logic [W-1:0]      w_sel_a;
    logic [W-1:0]      w_sel_b;
    logic              w_capture;
    logic              w_compute;
    logic [W:0]        w_result;

    logic [NREQ-1:0]   r_gnt;
    logic              r_busy;
    logic              r_op;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [IW-1:0]     r_idx;
    logic              r_res_valid;
    logic [2:0]        r_res_id;
    logic [W-1:0]      r_res_sum;
    logic              r_res_carry;

`ifdef ADDSUB_ARB_RR_EN
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     w_ptr_next;
    logic [IW:0]       w_scan_sum;
    logic [IW-1:0]     w_scan_idx;

    // Round-robin search: scan from the pointer, wrapping modulo NREQ, first hit wins
    always_comb begin
        w_any_req  = 1'b0;
        w_hit      = 1'b0;
        w_win_idx  = {IW{1'b0}};
        w_scan_sum = {(IW+1){1'b0}};
        w_scan_idx = {IW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            w_scan_sum = {1'b0, r_ptr} + (IW+1)'(k);
            w_scan_idx = (w_scan_sum >= (IW+1)'(NREQ)) ? IW'(w_scan_sum - (IW+1)'(NREQ))
                                                      : IW'(w_scan_sum);
            w_hit      = ~w_any_req & i_req[w_scan_idx];
            w_win_idx  = w_hit ? w_scan_idx : w_win_idx;
            w_any_req  = w_any_req | i_req[w_scan_idx];
        end
    end

    // Pointer moves one past the winner so the winner becomes lowest priority next time
    always_comb begin
        if (w_win_idx == IW'(NREQ - 1)) begin
            w_ptr_next = {IW{1'b0}};
        end else begin
            w_ptr_next = w_win_idx + IW'(1);
        end
    end

    // Arbitration pointer, advanced only when a grant is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= {IW{1'b0}};
        end else if (w_capture) begin
            r_ptr <= w_ptr_next;
        end else begin
            r_ptr <= r_ptr;
        end
    end
`else
    // Fixed priority: the lowest asserted index wins
    always_comb begin
        w_any_req = 1'b0;
        w_hit     = 1'b0;
        w_win_idx = {IW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            w_hit     = ~w_any_req & i_req[k];
            w_win_idx = w_hit ? IW'(k) : w_win_idx;
            w_any_req = w_any_req | i_req[k];
        end
    end
`endif

    // Winner one-hot and its operand slices
    always_comb begin
        w_win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_win_idx;
        w_sel_op     = 1'b0;
        w_sel_a      = {W{1'b0}};
        w_sel_b      = {W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            w_sel_op = (w_win_idx == IW'(k)) ? i_op[k]         : w_sel_op;
            w_sel_a  = (w_win_idx == IW'(k)) ? i_a[k*W +: W]   : w_sel_a;
            w_sel_b  = (w_win_idx == IW'(k)) ? i_b[k*W +: W]   : w_sel_b;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = ST_EXEC;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_EXEC: w_next_state = ST_RESP;
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM control decode: capture on IDLE->EXEC, compute on EXEC->RESP
    always_comb begin
        w_capture = 1'b0;
        w_compute = 1'b0;
        case (r_state)
            ST_IDLE: w_capture = w_any_req;
            ST_EXEC: w_compute = 1'b1;
            ST_RESP: w_compute = 1'b0;
            default: begin
                w_capture = 1'b0;
                w_compute = 1'b0;
            end
        endcase
    end

    // Shared arithmetic unit; subtract wraps modulo 2^W and reports no carry
    always_comb begin
        if (r_op) begin
            w_result = {1'b0, r_a - r_b};
        end else begin
            w_result = {1'b0, r_a} + {1'b0, r_b};
        end
    end

    // Grant pulse and operand capture; requesters may change inputs once granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt <= {NREQ{1'b0}};
            r_op  <= 1'b0;
            r_a   <= {W{1'b0}};
            r_b   <= {W{1'b0}};
            r_idx <= {IW{1'b0}};
        end else if (w_capture) begin
            r_gnt <= w_win_onehot;
            r_op  <= w_sel_op;
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
            r_idx <= w_win_idx;
        end else begin
            r_gnt <= {NREQ{1'b0}};
        end
    end

    // Busy flag mirrors the registered state being away from IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
        end
    end

    // Result registers hold their value until the next RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_id    <= 3'd0;
            r_res_sum   <= {W{1'b0}};
            r_res_carry <= 1'b0;
        end else if (w_compute) begin
            r_res_valid <= 1'b1;
            r_res_id    <= 3'(r_idx);
            r_res_sum   <= w_result[W-1:0];
            r_res_carry <= w_result[W];
        end else begin
            r_res_valid <= 1'b0;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_busy      = r_busy;
    assign o_res_valid = r_res_valid;
    assign o_res_id    = r_res_id;
    assign o_res_sum   = r_res_sum;
    assign o_res_carry = r_res_carry;

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Shares a single W-bit add/subtract datapath (add: {carry,sum}=a+b; sub: sum=a-b, carry=0) among NREQ requesters. The block arbitrates, captures the winner's operands, computes, and returns a tagged registered result. It sits between several control-path clients and the arithmetic unit, so no client ever drives the datapath directly.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- W, 4, operand/result width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level
- op  in  NREQ  per-requester operation; 0 = add, 1 = subtract
- a  in  NREQ*W  flattened operand A; requester i at bits [i*W+W-1 : i*W]
- b  in  NREQ*W  flattened operand B; same packing as a
- gnt  out  NREQ  one-hot grant, one-cycle pulse, marks operand capture
- busy  out  1  high whenever state is not IDLE
- res_valid  out  1  one-cycle result strobe
- res_id  out  3  index of the requester owning the result
- res_sum  out  W  result value
- res_carry  out  1  add carry-out; 0 for subtract

## Operation
- FSM states and transitions:
  - IDLE: if any req bit is high, select a winner and go to EXEC. Otherwise stay in IDLE.
  - EXEC: go to RESP unconditionally.
  - RESP: go to IDLE unconditionally.
- Entering EXEC registers the following: gnt = one-hot winner, the winner's op, a and b slices, and the winner index.
- gnt is high only during the EXEC cycle.
- Entering RESP registers the result. On that transition, add gives {res_carry,res_sum} = a+b, computed at W+1 bits. Subtract gives res_sum = (a-b) mod 2^W and res_carry = 0.
- res_valid and res_id are driven high/valid only during the RESP cycle.
- res_sum, res_carry and res_id hold their last values until the next RESP.
- req, op, a and b are sampled only in IDLE. A requester may change or drop them from the gnt cycle onward.
- If req is still high when the FSM returns to IDLE, it is a new request.
- A request withdrawn before it is sampled is lost silently; no gnt and no result are produced for it.
- Arbitration uses a pointer that is reset to 0. The pointer's update rule depends on configuration (see below).
- req bits at or above NREQ do not exist. res_id bits above log2(NREQ) read 0.

## Timing
- Latency: a req sampled in IDLE at edge k gives gnt in cycle k+1 (EXEC) and res_valid in cycle k+2 (RESP). The FSM is back in IDLE at cycle k+3.
- Throughput: one operation per 3 cycles. Back-to-back requesters are serviced with no idle gap.
- Simultaneous requests: exactly one winner per IDLE cycle. The losers stay pending and need no action.
- Reset values: state = IDLE, gnt = 0, busy = 0, res_valid = 0, res_id = 0, res_sum = 0, res_carry = 0, pointer = 0, internal operand registers = 0.
- Reset asserted mid-operation (EXEC or RESP) aborts immediately and asynchronously. No res_valid is issued for the aborted transaction.
- After rst_n deasserts, the first edge can sample requests.

## Configuration
- ADDSUB_ARB_RR_EN defined: round-robin arbitration.
  - The search starts at the pointer and wraps modulo NREQ.
  - On each grant, pointer = winner+1 mod NREQ.
  - Starvation-free: a continuously asserted request is granted within NREQ transactions.
- ADDSUB_ARB_RR_EN undefined: fixed priority.
  - The lowest requester index always wins.
  - The pointer is removed.
  - Higher indices may starve under continuous lower-index requests.

## Test plan
- Single add: req[2]=1, op[2]=0, a2=4'h9, b2=4'h8 in IDLE. Required: gnt=4'b0100 one cycle later, then res_valid=1, res_id=2, res_sum=4'h1, res_carry=1.
- Subtract wrap: req[0]=1, op=1, a0=4'h3, b0=4'h5. Required: res_sum=4'hE, res_carry=0. Also 4'hF-4'hF gives res_sum=0, res_carry=0.
- Contention with RR_EN: req=4'b1111 held for 12 cycles. Required: gnt sequence 0001, 0010, 0100, 1000, each 3 cycles apart.
- Same contention without RR_EN: required gnt = 0001 every time; requesters 1–3 never granted.
- Withdrawal and reset: req[1] pulsed for one cycle while busy gives no gnt[1] and no result. rst_n dropped during EXEC forces all outputs to 0 with no res_valid; the first request after release is granted normally, pointer starting at 0.
- Operand change after gnt: a1/b1 altered in the gnt cycle. Required: the result reflects the values captured in IDLE.
